// File: rtl/mac_pkg.sv
// Shared types and sizing helpers for the sequential dot-product MAC.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mac_state_e;

  // Product width plus headroom for SETS terms plus extra accumulation room.
  function automatic int mac_width(input int size, input int sets);
    return 2 * size + $clog2(sets) + 4;
  endfunction

  localparam int DEFAULT_SIZE  = 4;
  localparam int DEFAULT_SETS  = 2;
  localparam int DEFAULT_OUT_W = mac_width(DEFAULT_SIZE, DEFAULT_SETS);

endpackage

// File: rtl/seq_binary_mac_if.sv
// Request/response bundle of the MAC: request handshake with operands, result handshake.
interface seq_binary_mac_if
  import mac_pkg::*;
#(
  parameter int SIZE  = DEFAULT_SIZE,
  parameter int SETS  = DEFAULT_SETS,
  parameter int OUT_W = mac_width(SIZE, SETS)
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [SETS*SIZE-1:0] a;
  logic [SETS*SIZE-1:0] b;
  logic                 acc_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_W-1:0]     out;
  logic                 overflow;

  modport master (
    output in_valid, a, b, acc_mode, out_ready,
    input  in_ready, out_valid, out, overflow
  );

  modport slave (
    input  in_valid, a, b, acc_mode, out_ready,
    output in_ready, out_valid, out, overflow
  );

endinterface

// File: rtl/comb_binary_sub.sv
// Unsigned combinational shift-and-add multiplier, SIZE x SIZE -> 2*SIZE bits.
module comb_binary_sub #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0]   a_i,
  input  logic [SIZE-1:0]   b_i,
  output logic [2*SIZE-1:0] product_o
);

  logic [2*SIZE-1:0] a_ext;

  assign a_ext = {{SIZE{1'b0}}, a_i};

  // NOTE: blocking assignments are correct here -- each loop step reads the
  // running sum produced by the previous step within the same evaluation.
  always_comb begin
    product_o = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (b_i[i]) begin
        product_o = product_o + (a_ext << i);
      end
    end
  end

endmodule

// File: rtl/seq_binary_mac.sv
// Sequential dot-product MAC: one element pair per cycle through a shared multiplier.
module seq_binary_mac
  import mac_pkg::*;
#(
  parameter int SIZE  = DEFAULT_SIZE,
  parameter int SETS  = DEFAULT_SETS,
  parameter int OUT_W = mac_width(SIZE, SETS)
) (
  input logic             clock,
  input logic             reset,
  seq_binary_mac_if.slave bus
);

  localparam int IDX_W = (SETS > 1) ? $clog2(SETS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);

  mac_state_e           state_q, state_d;
  logic [OUT_W-1:0]     acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [SETS*SIZE-1:0] a_q, a_d;
  logic [SETS*SIZE-1:0] b_q, b_d;
  logic                 mode_q, mode_d;

  logic [SIZE-1:0]      a_el, b_el;
  logic [2*SIZE-1:0]    prod;
  logic [OUT_W-1:0]     acc_base;
  logic                 ovf_base;
  logic [OUT_W:0]       sum_w;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    a_el = '0;
    b_el = '0;
    for (int i = 0; i < SETS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_el = a_q[i*SIZE +: SIZE];
        b_el = b_q[i*SIZE +: SIZE];
      end
    end
  end

  comb_binary_sub #(
    .SIZE(SIZE)
  ) u_mul (
    .a_i      (a_el),
    .b_i      (b_el),
    .product_o(prod)
  );

  // First element of a fresh (non-accumulating) request always starts from zero.
  always_comb begin
    acc_base = acc_q;
    ovf_base = ovf_q;
    if ((idx_q == '0) && !mode_q) begin
      acc_base = '0;
      ovf_base = 1'b0;
    end
    sum_w = {1'b0, acc_base} + (OUT_W + 1)'(prod);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          mode_d  = bus.acc_mode;
          idx_d   = '0;
          state_d = BUSY;
          if (!bus.acc_mode) begin
            acc_d = '0;
            ovf_d = 1'b0;
          end
        end
      end
      BUSY: begin
        acc_d = sum_w[OUT_W-1:0];
        ovf_d = ovf_base | sum_w[OUT_W];
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot. The operand
  // registers are plain flops, so clearing them on reset is cheap.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out       = acc_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_seq_binary_mac.sv
// Directed bench for seq_binary_mac with a result scoreboard and an arithmetic reference model.
module tb_seq_binary_mac;

  localparam int SIZE    = 4;
  localparam int SETS    = 2;
  localparam int OUT_W   = 13;
  localparam int TIMEOUT = 40;

  typedef struct {
    logic [OUT_W-1:0] out;
    logic             ovf;
  } exp_t;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  seq_binary_mac_if #(.SIZE(SIZE), .SETS(SETS), .OUT_W(OUT_W)) bus ();

  seq_binary_mac #(.SIZE(SIZE), .SETS(SETS), .OUT_W(OUT_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int               checks = 0;
  int               errors = 0;
  exp_t             sb[$];
  logic [OUT_W-1:0] m_acc = '0;
  logic             m_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [OUT_W:0] dot(input logic [SETS*SIZE-1:0] a, input logic [SETS*SIZE-1:0] b);
    logic [OUT_W:0] s = '0;
    for (int i = 0; i < SETS; i++) begin
      s = s + (OUT_W + 1)'(a[i*SIZE +: SIZE]) * (OUT_W + 1)'(b[i*SIZE +: SIZE]);
    end
    return s;
  endfunction

  task automatic model_accept(input logic [SETS*SIZE-1:0] a, input logic [SETS*SIZE-1:0] b, input logic mode);
    logic [OUT_W:0] sum;
    if (!mode) begin
      m_acc = '0;
      m_ovf = 1'b0;
    end
    sum   = {1'b0, m_acc} + dot(a, b);
    m_acc = sum[OUT_W-1:0];
    m_ovf = m_ovf | sum[OUT_W];
    sb.push_back('{out: m_acc, ovf: m_ovf});
  endtask

  // Starts and ends just after a falling edge; returns after the acceptance edge.
  task automatic issue(input logic [SETS*SIZE-1:0] a, input logic [SETS*SIZE-1:0] b, input logic mode);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.acc_mode = mode;
    while (bus.in_ready !== 1'b1 && n < TIMEOUT) begin
      @(posedge clock);
      @(negedge clock);
      n++;
    end
    check("accept_wait", 32'(n < TIMEOUT), 1);
    @(posedge clock);
    model_accept(a, b, mode);
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask

  // Waits for the result, compares against the scoreboard, optionally stalls, then releases.
  task automatic collect(input string tag, input int hold);
    int   lat = 0;
    exp_t e;
    while (bus.out_valid !== 1'b1 && lat < TIMEOUT) begin
      @(posedge clock);
      @(negedge clock);
      lat++;
    end
    check({tag, "_latency"}, lat, SETS);
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_out"}, bus.out, e.out);
      check({tag, "_ovf"}, bus.overflow, e.ovf);
      for (int k = 0; k < hold; k++) begin
        bus.in_valid = 1'b1;
        bus.a        = 8'hFF;
        bus.b        = 8'hFF;
        bus.acc_mode = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check({tag, "_hold_valid"}, bus.out_valid, 1);
        check({tag, "_hold_out"}, bus.out, e.out);
        check({tag, "_hold_ready"}, bus.in_ready, 0);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.out_ready = 1'b0;
    check({tag, "_idle_ready"}, bus.in_ready, 1);
    check({tag, "_idle_valid"}, bus.out_valid, 0);
  endtask

  task automatic run_req(input logic [SETS*SIZE-1:0] a, input logic [SETS*SIZE-1:0] b,
                         input logic mode, input string tag);
    issue(a, b, mode);
    collect(tag, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_acc;
    int n_acc;
    int n;
    exp_t e;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.acc_mode  = 1'b0;
    bus.out_ready = 1'b0;

    @(negedge clock);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out", bus.out, 0);
    check("rst_ovf", bus.overflow, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_in_ready", bus.in_ready, 1);
    check("post_rst_out", bus.out, 0);

    // Basic dot product: 2*5 + 3*7
    run_req(8'h32, 8'h75, 1'b0, "basic");
    check("basic_const", bus.out, 31);
    check("basic_ovf_const", bus.overflow, 0);

    // Maximum operands, then accumulate once
    run_req(8'hFF, 8'hFF, 1'b0, "max");
    check("max_const", bus.out, 450);
    run_req(8'hFF, 8'hFF, 1'b1, "acc");
    check("acc_const", bus.out, 900);

    // 19 * 450 = 8550 wraps to 358 with the sticky carry set
    for (int i = 0; i < 19; i++) begin
      run_req(8'hFF, 8'hFF, (i != 0), "ovf_run");
    end
    check("ovf_out_const", bus.out, 358);
    check("ovf_flag_const", bus.overflow, 1);
    run_req(8'h32, 8'h75, 1'b0, "ovf_clear");
    check("ovf_clear_out", bus.out, 31);
    check("ovf_clear_flag", bus.overflow, 0);

    // Backpressure: result held for 5 cycles while a new request is offered
    issue(8'h32, 8'h75, 1'b1);
    collect("bp", 5);
    check("bp_after_out", bus.out, 62);

    // Reset one cycle after acceptance
    issue(8'hFF, 8'hFF, 1'b1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("midbusy_in_ready", bus.in_ready, 1);
    check("midbusy_out_valid", bus.out_valid, 0);
    check("midbusy_out", bus.out, 0);
    check("midbusy_ovf", bus.overflow, 0);
    reset = 1'b0;
    sb.delete();
    m_acc = '0;
    m_ovf = 1'b0;
    run_req(8'hFF, 8'hFF, 1'b1, "after_rst");
    check("after_rst_const", bus.out, 450);

    // Back-to-back: in_valid and out_ready held high
    bus.in_valid  = 1'b1;
    bus.a         = 8'h32;
    bus.b         = 8'h75;
    bus.acc_mode  = 1'b0;
    bus.out_ready = 1'b1;
    last_acc = -1;
    n_acc    = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (bus.out_valid === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        check("b2b_out", bus.out, e.out);
      end
      if (bus.in_ready === 1'b1) begin
        if (last_acc >= 0) begin
          check("b2b_period", cyc - last_acc, SETS + 2);
        end
        last_acc = cyc;
        n_acc++;
        model_accept(8'h32, 8'h75, 1'b0);
      end
      @(posedge clock);
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
    check("b2b_count", 32'(n_acc >= 3), 1);
    n = 0;
    while (sb.size() > 0 && n < TIMEOUT) begin
      if (bus.out_valid === 1'b1) begin
        e = sb.pop_front();
        check("b2b_drain_out", bus.out, e.out);
      end
      @(posedge clock);
      @(negedge clock);
      n++;
    end
    bus.out_ready = 1'b0;
    check("b2b_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
